// File: rtl/reset_sequencer_pkg.sv
// Shared types for the reset sequencer: FSM state encoding (also exported as
// the status-register view) and a small elaboration-time helper.
package reset_seq_pkg;

   typedef enum logic [2:0] {
      HOLD      = 3'd0,
      WAIT_LOCK = 3'd1,
      RELEASE   = 3'd2,
      RUN       = 3'd3,
      FAULT     = 3'd4
   } seq_state_t;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/reset_sequencer_lock_sync.sv
// Two-flop synchronizer for the PLL lock indication, with a synchronous clear
// so the sequencer never sees a stale lock right after reset.
module lock_sync (
   input  logic clk,
   input  logic clr,
   input  logic d,
   output logic q
);

   (* ASYNC_REG = "TRUE" *) logic [1:0] sync_q;

   always_ff @(posedge clk) begin
      if (clr) sync_q <= '0;
      else     sync_q <= {sync_q[0], d};
   end

   assign q = sync_q[1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset release: hold, wait for stable PLL lock, then deassert the
// per-domain active-low resets one at a time; all resets re-assert together.
module reset_sequencer
   import reset_seq_pkg::*;
#(
   parameter int NUM_STAGES          = 4,
   parameter int HOLD_CYCLES         = 16,
   parameter int LOCK_STABLE_CYCLES  = 8,
   parameter int STAGE_GAP_CYCLES    = 4,
   parameter int LOCK_TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  pll_locked,
   input  logic                  sw_reset_req,
   output logic [NUM_STAGES-1:0] stage_rst_n,
   output logic                  seq_done,
   output logic                  lock_fault,
   output logic [2:0]            seq_state
);

   localparam int CW = $clog2(max_int(max_int(HOLD_CYCLES, LOCK_STABLE_CYCLES),
                                      STAGE_GAP_CYCLES)) + 1;
   localparam int TW = $clog2(LOCK_TIMEOUT_CYCLES) + 1;
   localparam int IW = (NUM_STAGES > 1) ? $clog2(NUM_STAGES) : 1;

   seq_state_t            state_q, state_d;
   logic [CW-1:0]         cnt_q, cnt_d, cnt_inc;
   logic [TW-1:0]         tmo_q, tmo_d, tmo_inc;
   logic [IW-1:0]         idx_q, idx_d;
   logic [NUM_STAGES-1:0] stage_rst_n_d;
   logic                  seq_done_d, lock_fault_d;
   logic                  lock_s;

   lock_sync u_lock_sync (
      .clk (clk),
      .clr (rst),
      .d   (pll_locked),
      .q   (lock_s)
   );

   assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CW'(1);
   assign tmo_inc = (&tmo_q) ? tmo_q : tmo_q + TW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= HOLD;
         cnt_q       <= '0;
         tmo_q       <= '0;
         idx_q       <= '0;
         stage_rst_n <= '0;
         seq_done    <= 1'b0;
         lock_fault  <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         tmo_q       <= tmo_d;
         idx_q       <= idx_d;
         stage_rst_n <= stage_rst_n_d;
         seq_done    <= seq_done_d;
         lock_fault  <= lock_fault_d;
      end
   end

   // Re-entering HOLD counts the entry edge as the first hold cycle; after rst
   // the counter starts at 0 so cycle 0 is the first edge with rst low.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tmo_d   = '0;
      idx_d   = idx_q;
      if (sw_reset_req) begin
         state_d = HOLD;
         cnt_d   = CW'(1);
         idx_d   = '0;
      end else begin
         case (state_q)
            HOLD: begin
               if (cnt_q == CW'(HOLD_CYCLES)) begin
                  state_d = WAIT_LOCK;
                  cnt_d   = '0;
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            WAIT_LOCK: begin
               tmo_d = tmo_inc;
               cnt_d = lock_s ? cnt_inc : '0;
               if (lock_s && cnt_inc == CW'(LOCK_STABLE_CYCLES)) begin
                  state_d = RELEASE;
                  cnt_d   = '0;
                  idx_d   = '0;
               end else if (tmo_inc == TW'(LOCK_TIMEOUT_CYCLES)) begin
                  state_d = FAULT;
                  cnt_d   = '0;
               end
            end
            RELEASE: begin
               if (!lock_s) begin
                  state_d = HOLD;
                  cnt_d   = CW'(1);
                  idx_d   = '0;
               end else if (cnt_inc == CW'(STAGE_GAP_CYCLES)) begin
                  cnt_d = '0;
                  if (idx_q == IW'(NUM_STAGES - 1)) state_d = RUN;
                  else                              idx_d   = idx_q + IW'(1);
               end else begin
                  cnt_d = cnt_inc;
               end
            end
            RUN: begin
               if (!lock_s) begin
                  state_d = HOLD;
                  cnt_d   = CW'(1);
                  idx_d   = '0;
               end
            end
            FAULT:   ;
            default: begin
               state_d = HOLD;
               cnt_d   = '0;
               idx_d   = '0;
            end
         endcase
      end
   end

   // Outputs are decoded from the next state so they register on the same
   // edge as the state change.
   always_comb begin
      stage_rst_n_d = '0;
      seq_done_d    = (state_d == RUN);
      lock_fault_d  = (state_d == FAULT);
      case (state_d)
         RELEASE: for (int i = 0; i < NUM_STAGES; i++) stage_rst_n_d[i] = (IW'(i) <= idx_d);
         RUN:     stage_rst_n_d = '1;
         default: stage_rst_n_d = '0;
      endcase
   end

   assign seq_state = state_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: power-up vector table, directed corner sequences
// and a randomized phase, all checked against a timestamp-based reference model.
module tb_reset_sequencer;
   import reset_seq_pkg::*;

   localparam int NS  = 4;
   localparam int HC  = 16;
   localparam int LS  = 8;
   localparam int GAP = 4;
   localparam int TO  = 1024;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          pll_locked = 1'b0;
   logic          sw_reset_req = 1'b0;
   logic [NS-1:0] stage_rst_n;
   logic          seq_done;
   logic          lock_fault;
   logic [2:0]    seq_state;

   int total = 0;
   int bad   = 0;
   int cyc   = -1;
   int t0    = 0;

   // reference model: phase plus the edge at which the phase's timing began
   seq_state_t    m_st = HOLD;
   int            m_entry = 0;
   int            m_run = 0;
   logic          m_s1 = 1'b0, m_s2 = 1'b0;
   logic [NS-1:0] m_stage = '0;
   logic          m_done = 1'b0, m_fault = 1'b0;

   typedef struct {
      int            cyc;
      logic [NS-1:0] stage;
      logic          done;
   } vec_t;
   vec_t vt[10];

   always #5 clk = ~clk;

   reset_sequencer #(
      .NUM_STAGES(NS), .HOLD_CYCLES(HC), .LOCK_STABLE_CYCLES(LS),
      .STAGE_GAP_CYCLES(GAP), .LOCK_TIMEOUT_CYCLES(TO)
   ) dut (
      .clk(clk), .rst(rst), .pll_locked(pll_locked), .sw_reset_req(sw_reset_req),
      .stage_rst_n(stage_rst_n), .seq_done(seq_done), .lock_fault(lock_fault),
      .seq_state(seq_state)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s cycle=%0d got=%0h want=%0h", name, cyc - t0, act, exp);
      end
   endtask

   task automatic model_edge();
      logic ls;
      int   k;
      ls = m_s2;
      if (rst) begin m_s1 = 1'b0; m_s2 = 1'b0; end
      else begin m_s2 = m_s1; m_s1 = pll_locked; end
      if (rst) begin
         m_st = HOLD; m_entry = cyc + 1;
      end else if (sw_reset_req) begin
         m_st = HOLD; m_entry = cyc;
      end else begin
         case (m_st)
            HOLD: if (cyc - m_entry == HC) begin m_st = WAIT_LOCK; m_entry = cyc; m_run = 0; end
            WAIT_LOCK: begin
               m_run = ls ? m_run + 1 : 0;
               if (m_run >= LS)              begin m_st = RELEASE; m_entry = cyc; end
               else if (cyc - m_entry >= TO) m_st = FAULT;
            end
            RELEASE: begin
               if (!ls)                           begin m_st = HOLD; m_entry = cyc; end
               else if (cyc - m_entry >= NS * GAP) m_st = RUN;
            end
            RUN:     if (!ls) begin m_st = HOLD; m_entry = cyc; end
            default: ;
         endcase
      end
      m_stage = '0;
      if (m_st == RELEASE) begin
         k = (cyc - m_entry) / GAP;
         for (int i = 0; i < NS; i++) m_stage[i] = (i <= k);
      end else if (m_st == RUN) begin
         m_stage = '1;
      end
      m_done  = (m_st == RUN);
      m_fault = (m_st == FAULT);
   endtask

   task automatic tick();
      @(posedge clk);
      cyc++;
      model_edge();
      #1;
      check("model", {stage_rst_n, seq_done, lock_fault, seq_state},
                     {m_stage, m_done, m_fault, 3'(m_st)});
   endtask

   task automatic run_to(input int r);
      while (cyc - t0 < r) tick();
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1; sw_reset_req = 1'b0;
      repeat (n) tick();
      check("reset_vals", {stage_rst_n, seq_done, lock_fault, seq_state}, '0);
      rst = 1'b0;
      t0 = cyc + 1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vt[0] = '{0,  4'b0000, 1'b0};
      vt[1] = '{23, 4'b0000, 1'b0};
      vt[2] = '{24, 4'b0001, 1'b0};
      vt[3] = '{27, 4'b0001, 1'b0};
      vt[4] = '{28, 4'b0011, 1'b0};
      vt[5] = '{32, 4'b0111, 1'b0};
      vt[6] = '{35, 4'b0111, 1'b0};
      vt[7] = '{36, 4'b1111, 1'b0};
      vt[8] = '{39, 4'b1111, 1'b0};
      vt[9] = '{40, 4'b1111, 1'b1};

      // power-up with lock high
      pll_locked = 1'b1;
      do_reset(3);
      for (int i = 0; i < 10; i++) begin
         run_to(vt[i].cyc);
         check("pwrup_stage", stage_rst_n, vt[i].stage);
         check("pwrup_done", seq_done, vt[i].done);
      end
      check("pwrup_state_run", seq_state, 3'd3);

      // lock drop in RUN, then resequence
      run_to(45); pll_locked = 1'b0;
      run_to(47); check("drop_still_up", stage_rst_n, 4'b1111);
      run_to(48); check("drop_stage", stage_rst_n, 4'b0000);
      check("drop_done", seq_done, 1'b0);
      pll_locked = 1'b1;
      run_to(87); check("reseq_done_early", seq_done, 1'b0);
      run_to(88); check("reseq_done", seq_done, 1'b1);
      check("reseq_stage", stage_rst_n, 4'b1111);

      // one-cycle lock glitch during WAIT_LOCK
      do_reset(2);
      run_to(20); pll_locked = 1'b0;
      run_to(21); pll_locked = 1'b1;
      run_to(30); check("glitch_not_yet", stage_rst_n, 4'b0000);
      run_to(31); check("glitch_release", stage_rst_n, 4'b0001);

      // software reset mid-RELEASE
      do_reset(2);
      run_to(30); check("sw_pre", stage_rst_n, 4'b0011);
      sw_reset_req = 1'b1;
      run_to(31); sw_reset_req = 1'b0;
      check("sw_stage", stage_rst_n, 4'b0000);
      check("sw_state", seq_state, 3'd0);
      run_to(54); check("sw_rel_early", stage_rst_n, 4'b0000);
      run_to(55); check("sw_rel", stage_rst_n, 4'b0001);

      // rst coincident with sw_reset_req in RUN
      do_reset(2);
      run_to(42); check("rstsw_pre", seq_done, 1'b1);
      rst = 1'b1; sw_reset_req = 1'b1;
      tick();
      check("rstsw_vals", {stage_rst_n, seq_done, lock_fault, seq_state}, '0);
      rst = 1'b0; sw_reset_req = 1'b0; t0 = cyc + 1;
      run_to(23); check("rstsw_early", stage_rst_n, 4'b0000);
      run_to(24); check("rstsw_rel", stage_rst_n, 4'b0001);

      // lock never arrives: timeout, then software recovery
      pll_locked = 1'b0;
      do_reset(2);
      run_to(HC + TO - 1); check("to_wait", seq_state, 3'd1);
      run_to(HC + TO);     check("to_state", seq_state, 3'd4);
      check("to_fault", lock_fault, 1'b1);
      check("to_stage", stage_rst_n, 4'b0000);
      run_to(HC + TO + 5); check("to_sticky", lock_fault, 1'b1);
      sw_reset_req = 1'b1;
      run_to(HC + TO + 6); sw_reset_req = 1'b0;
      check("to_clear", lock_fault, 1'b0);
      check("to_hold", seq_state, 3'd0);
      pll_locked = 1'b1;
      run_to(HC + TO + 6 + 23); check("to_rel_early", stage_rst_n, 4'b0000);
      run_to(HC + TO + 6 + 24); check("to_rel", stage_rst_n, 4'b0001);

      // randomized phase, model-checked every edge
      for (int n = 0; n < 4000; n++) begin
         rst          = ($urandom_range(0, 499) == 0);
         sw_reset_req = ($urandom_range(0, 149) == 0);
         if (pll_locked) pll_locked = ($urandom_range(0, 149) != 0);
         else            pll_locked = ($urandom_range(0, 9) == 0);
         tick();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
